bus_arbiter: RTL

N-master, single-slave bus arbiter for the Z80 computer memory bus. It replaces the hard-wired cpu/uart master muxing with one parametrised block. It grants exactly one master at a time and supports two arbitration modes: fixed priority or round-robin. It forwards the granted master's address, data, write-enable and chip-select to the shared bus, and returns ack and read data. A per-transaction watchdog terminates stuck accesses with an error flag.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter_arb_pick.sv | 31 +++
 rtl/bus_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and sizing helpers for the Z80 bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  // Ceiling log2 that never returns less than 1, so single-bit indices stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`define BUS_ARB_IDX_W(n) (bus_arbiter_pkg::clog2_min1(n))

// File: rtl/bus_arbiter_if.sv
// Master-side requests, shared slave bus and per-master responses of the arbiter.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
);
  logic [NUM_MASTERS-1:0]        i_m_cs;
  logic [NUM_MASTERS-1:0]        i_m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat;
  logic [NUM_MASTERS-1:0]        o_m_ack;
  logic [NUM_MASTERS-1:0]        o_m_err;
  logic [DATA_W-1:0]             o_m_dat;
  logic [NUM_MASTERS-1:0]        o_grant;
  logic [ADDR_W-1:0]             o_addr;
  logic [DATA_W-1:0]             o_dat;
  logic                          o_we;
  logic                          o_cs;
  logic                          i_ack;
  logic [DATA_W-1:0]             i_dat;

  // Handshake: a master holds i_m_cs (with stable we/addr/dat) until its o_m_ack
  // pulse; each cycle with o_m_ack high completes one access, o_m_err marks a timeout.
  // master: the arbiter, which masters the shared slave bus.
  modport master (
    input  i_m_cs, i_m_we, i_m_addr, i_m_dat, i_ack, i_dat,
    output o_m_ack, o_m_err, o_m_dat, o_grant, o_addr, o_dat, o_we, o_cs
  );
  // slave: the environment (requesting masters and the slave device).
  modport slave (
    output i_m_cs, i_m_we, i_m_addr, i_m_dat, i_ack, i_dat,
    input  o_m_ack, o_m_err, o_m_dat, o_grant, o_addr, o_dat, o_we, o_cs
  );
endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational winner selector: fixed (lowest index) or rotating from a start index.
module arb_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  input  logic          i_rr,
  output logic [N-1:0]  o_win,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  int cand;

  always_comb begin
    o_win   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      // i_start is always < N, so one subtraction gives the modulo-N wrap.
      cand = i_rr ? (int'(i_start) + i) : i;
      if (cand >= N) cand = cand - N;
      if (!o_valid && i_req[cand]) begin
        o_valid     = 1'b1;
        o_win[cand] = 1'b1;
        o_idx       = IW'(cand);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter with registered grant and per-access watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bus_arbiter_if.master bus,
  output state_e        o_dbg_state
);
  localparam int IW   = `BUS_ARB_IDX_W(NUM_MASTERS);
  localparam int WD_W = clog2_min1(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = '1;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          rr_last_q, rr_last_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [IW-1:0]          rr_start;
  logic [NUM_MASTERS-1:0] win;
  logic [IW-1:0]          win_idx;
  logic                   win_valid;
  logic                   owned, g_cs, timeout_hit, ack_g;

  assign rr_start = (rr_last_q == IW'(NUM_MASTERS - 1)) ? '0 : rr_last_q + 1'b1;

  arb_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .i_req   (bus.i_m_cs),
    .i_start (rr_start),
    .i_rr    (ROUND_ROBIN != 0),
    .o_win   (win),
    .o_idx   (win_idx),
    .o_valid (win_valid)
  );

  assign owned       = (state_q == OWNED);
  assign g_cs        = owned & bus.i_m_cs[gidx_q];
  assign timeout_hit = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1)) && g_cs && !bus.i_ack;
  assign ack_g       = g_cs & (bus.i_ack | timeout_hit);

  assign bus.o_cs    = g_cs;
  assign bus.o_we    = owned & bus.i_m_we[gidx_q];
  assign bus.o_addr  = owned ? bus.i_m_addr[int'(gidx_q)*ADDR_W +: ADDR_W] : '0;
  assign bus.o_dat   = owned ? bus.i_m_dat[int'(gidx_q)*DATA_W +: DATA_W] : '0;
  assign bus.o_grant = grant_q;
  assign bus.o_m_ack = ack_g ? grant_q : '0;
  assign bus.o_m_err = timeout_hit ? grant_q : '0;
  assign bus.o_m_dat = bus.i_dat;
  assign o_dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_last_d = rr_last_q;
    wd_d      = wd_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = OWNED;
          grant_d   = win;
          gidx_d    = win_idx;
          rr_last_d = win_idx;
          wd_d      = '0;
        end
      end
      OWNED: begin
        if (!bus.i_m_cs[gidx_q]) begin
          // Owner released: hand over directly if anyone else is waiting.
          wd_d = '0;
          if (win_valid) begin
            grant_d   = win;
            gidx_d    = win_idx;
            rr_last_d = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (ack_g) begin
          wd_d = '0;
        end else if (!bus.i_ack && wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_last_q <= IW'(NUM_MASTERS - 1);
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_last_q <= rr_last_d;
      wd_q      <= wd_d;
    end
  end
endmodule
